rr_bus_arbiter: RTL and testbench
=================================

Name: rr_bus_arbiter

Overview:
- Round-robin arbiter that shares one system bus among N masters.
- Extends the two-master fixed A/B arbiter to N requesters with a fair rotating pointer.
- Adds a bounded tenure counter with preemption, an owner lock that blocks preemption, and one dead bus cycle between owners.
- Sits between the master request lines and the bus mux select.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_TENURE, 8, cycles an owner keeps the bus before it can be preempted (>=2).
- IDW, $clog2(N), width of gnt_id.
- TW, $clog2(MAX_TENURE), width of the tenure counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  N  request per master; level-sensitive; held high for the whole tenure.
- lock  in  1  asserted by the current owner to forbid preemption; ignored when there is no owner.
- gnt  out  N  one-hot grant, registered; all-zero when the bus is idle.
- gnt_id  out  IDW  binary index of the owner; holds the last owner while idle.
- busy  out  1  high while in GRANT.
- preempt  out  1  one-cycle registered pulse marking a tenure ended by timeout.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, gnt=0, gnt_id=0, busy=0, preempt=0, ptr=0, tenure=0. Outputs clear immediately, without waiting for a clock edge.
- States: IDLE and GRANT.
- Winner selection: lowest index i such that req[i]=1, searching ptr, ptr+1, ... N-1, then 0 ... ptr-1.
- IDLE, some req set at an edge:
  - gnt <= onehot(winner), gnt_id <= winner.
  - ptr <= (winner+1) mod N.
  - tenure <= 0, state <= GRANT.
  - Latency: req high before edge k gives gnt visible after edge k.
- IDLE, req=0: remain in IDLE with gnt=0.
- GRANT, each edge, evaluated in priority order:
  1. req[gnt_id]=0 (release): gnt <= 0, state <= IDLE, preempt <= 0.
  2. Preemption, when all three hold: tenure==MAX_TENURE-1, lock=0, and (req & ~gnt)!=0. Then gnt <= 0, state <= IDLE, preempt <= 1.
  3. Otherwise hold the grant. tenure <= tenure+1, saturating at MAX_TENURE-1. preempt <= 0.
- preempt is high for exactly the one cycle following the preempting edge; otherwise 0.
- After every tenure the bus is idle (gnt=0) for at least one cycle. There is no back-to-back grant.
- Owner alone on the bus: tenure saturates and the owner keeps the bus indefinitely, with no preempt.
- lock high at saturation: hold. When lock falls while others are pending, preemption happens at the next edge.
- Release and timeout on the same edge: release wins, preempt=0.
- A requester that drops req while not owner is forgotten; there is no request latching.
- ptr wraps from N-1 to 0.
- gnt is never multi-hot and never grants an index whose req was low at the granting edge.
- Reset mid-tenure: grant is lost immediately. After reset release, arbitration restarts with ptr=0.

Decomposition:
- Shared package arb_pkg holds:
  - state enumeration {IDLE, GRANT};
  - default N and MAX_TENURE constants;
  - onehot-from-index helper function.
- One sub-module, rr_pick: purely combinational rotate-priority picker.
  - Inputs: req[N], ptr[IDW].
  - Outputs: valid, idx[IDW].
  - Instantiated once.
- The FSM, tenure counter and pointer register live in rr_bus_arbiter.

Test Plan (N=4, MAX_TENURE=4):
- Reset: hold rst=0 with req=1111 -> gnt=0000, gnt_id=0, busy=0, preempt=0 throughout. Release rst -> first grant is 0001 at the next edge.
- Single master: req=0010 from cycle 0, dropped at cycle 3 -> gnt=0010, gnt_id=1 from cycle 1 to cycle 3; gnt=0000 from cycle 4; no preempt.
- Full contention: req=1111 continuously, lock=0 -> gnt sequence is 0001 x4, 0000, 0010 x4, 0000, 0100 x4, 0000, 1000 x4, 0000, 0001... preempt pulses in each 0000 cycle.
- Lock: owner 0 holds lock=1 with req=1111 for 10 cycles -> gnt=0001 for all 10 cycles, no preempt. lock falls -> gnt=0000 and preempt=1 next cycle, then gnt=0010.
- Sole owner and simultaneous events:
  - req=0100 alone for 12 cycles -> gnt=0100 held 12 cycles, preempt=0.
  - Owner drops req on the timeout edge while req=1111 otherwise -> preempt stays 0.
- Async reset mid-tenure: pull rst low between edges while gnt=0100 -> gnt=0000 before the next edge. After release with req=1111 -> gnt=0001.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
package arb_pkg;

    localparam int DEF_N          = 4;
    localparam int DEF_MAX_TENURE = 8;
    localparam int MAX_N          = 16;
    localparam int MAX_IDW        = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Widest one-hot vector; callers truncate to their own requester count.
    function automatic logic [MAX_N-1:0] onehot(input logic [MAX_IDW-1:0] idx);
        return MAX_N'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_bus_arbiter_if.sv
// Request/grant bundle between the bus masters and the arbiter.
interface rr_bus_arbiter_if #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) ();

    logic [N-1:0]   req;
    logic           lock;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           preempt;

    modport master (
        output req, lock,
        input  gnt, gnt_id, busy, preempt
    );

    modport slave (
        input  req, lock,
        output gnt, gnt_id, busy, preempt
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr, wrapping.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           valid,
    output logic [IDW-1:0] idx
);

    logic [IDW:0] cand;

    // Scan from the farthest offset back toward ptr so the nearest hit wins last.
    always_comb begin
        idx  = ptr;
        cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(N)) begin
                cand = cand - (IDW+1)'(N);
            end
            if (req[cand[IDW-1:0]]) begin
                idx = cand[IDW-1:0];
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/rr_bus_arbiter.sv
// N-master round-robin bus arbiter with bounded tenure, owner lock and a dead cycle between owners.
module rr_bus_arbiter
    import arb_pkg::*;
#(
    parameter int N          = DEF_N,
    parameter int MAX_TENURE = DEF_MAX_TENURE,
    parameter int IDW        = $clog2(N),
    parameter int TW         = $clog2(MAX_TENURE)
) (
    input  logic             clk,
    input  logic             rst,
    rr_bus_arbiter_if.slave  bus
);

    arb_state_t     state, state_d;
    logic [N-1:0]   gnt, gnt_d;
    logic [IDW-1:0] gnt_id, gnt_id_d;
    logic [IDW-1:0] ptr, ptr_d;
    logic [TW-1:0]  tenure, tenure_d;
    logic           preempt, preempt_d;

    logic           pick_valid;
    logic [IDW-1:0] pick_idx;
    logic           sat;
    logic           others;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign sat    = (tenure == TW'(MAX_TENURE - 1));
    assign others = |(bus.req & ~gnt);

    // NOTE: every output of this block gets a default first, so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d   = state;
        gnt_d     = gnt;
        gnt_id_d  = gnt_id;
        ptr_d     = ptr;
        tenure_d  = tenure;
        preempt_d = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_d  = GRANT;
                    gnt_d    = N'(onehot(MAX_IDW'(pick_idx)));
                    gnt_id_d = pick_idx;
                    ptr_d    = (pick_idx == IDW'(N - 1)) ? '0 : pick_idx + IDW'(1);
                    tenure_d = '0;
                end
            end
            GRANT: begin
                // Release outranks timeout, so a simultaneous drop never pulses preempt.
                if (!bus.req[gnt_id]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else if (sat && !bus.lock && others) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    preempt_d = 1'b1;
                end else if (!sat) begin
                    tenure_d = tenure + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            ptr     <= '0;
            tenure  <= '0;
            preempt <= 1'b0;
        end else begin
            state   <= state_d;
            gnt     <= gnt_d;
            gnt_id  <= gnt_id_d;
            ptr     <= ptr_d;
            tenure  <= tenure_d;
            preempt <= preempt_d;
        end
    end

    assign bus.gnt     = gnt;
    assign bus.gnt_id  = gnt_id;
    assign bus.busy    = (state == GRANT);
    assign bus.preempt = preempt;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Self-checking bench for rr_bus_arbiter (N=4, MAX_TENURE=4): scoreboard model plus directed scenarios.
module tb_rr_bus_arbiter;

    localparam int N  = 4;
    localparam int MT = 4;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       pre;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;
    exp_t sb[$];

    rr_bus_arbiter_if #(.N(N)) bus ();

    rr_bus_arbiter #(
        .N          (N),
        .MAX_TENURE (MT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: written from the arbitration rules, one expected output set per edge.
    int m_busy, m_id, m_ptr, m_ten, m_pre;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 0; m_id = 0; m_ptr = 0; m_ten = 0; m_pre = 0;
            sb.delete();
        end else begin
            exp_t e;
            if (m_busy == 0) begin
                m_pre = 0;
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (m_busy == 0 && bus.req[c]) begin
                        m_busy = 1; m_id = c; m_ptr = (c + 1) % N; m_ten = 0;
                    end
                end
            end else if (!bus.req[m_id]) begin
                m_busy = 0; m_pre = 0;
            end else if (m_ten == MT - 1 && !bus.lock && (bus.req & ~(4'b0001 << m_id)) != 4'b0) begin
                m_busy = 0; m_pre = 1;
            end else begin
                if (m_ten < MT - 1) m_ten++;
                m_pre = 0;
            end
            e.gnt  = (m_busy != 0) ? (4'b0001 << m_id) : 4'b0000;
            e.id   = 2'(m_id);
            e.busy = (m_busy != 0);
            e.pre  = (m_pre != 0);
            sb.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_gnt",  bus.gnt,     0);
            check("rst_id",   bus.gnt_id,  0);
            check("rst_busy", bus.busy,    0);
            check("rst_pre",  bus.preempt, 0);
        end else if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("sb_gnt",  bus.gnt,     e.gnt);
            check("sb_id",   bus.gnt_id,  e.id);
            check("sb_busy", bus.busy,    e.busy);
            check("sb_pre",  bus.preempt, e.pre);
        end
    end

    // Returns at a falling edge with rst just released and inputs idle.
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        bus.req  = '0;
        bus.lock = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    logic [3:0] pat [20] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0,
                             4'h2, 4'h2, 4'h2, 4'h2, 4'h0,
                             4'h4, 4'h4, 4'h4, 4'h4, 4'h0,
                             4'h8, 4'h8, 4'h8, 4'h8, 4'h0};

    initial begin
        bus.req  = 4'hf;
        bus.lock = 1'b0;

        // Reset held with every master requesting.
        repeat (3) @(negedge clk);
        check("hold_gnt", bus.gnt, 0);
        rst = 1'b1;
        @(negedge clk);
        check("first_gnt", bus.gnt, 4'h1);

        // Single master, dropped at cycle 3.
        do_reset();
        bus.req = 4'h2;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check($sformatf("single_gnt%0d", i), bus.gnt, 4'h2);
            check($sformatf("single_id%0d", i), bus.gnt_id, 1);
        end
        bus.req = 4'h0;
        @(negedge clk);
        check("single_rel_gnt", bus.gnt, 0);
        check("single_rel_pre", bus.preempt, 0);

        // Full contention: rotation with one dead preempt cycle between owners.
        do_reset();
        bus.req = 4'hf;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("cont_gnt%0d", i), bus.gnt, pat[i]);
            check($sformatf("cont_pre%0d", i), bus.preempt, (pat[i] == 4'h0));
        end

        // Lock holds the bus past saturation; dropping it preempts at the next edge.
        do_reset();
        bus.req  = 4'hf;
        bus.lock = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("lock_gnt%0d", i), bus.gnt, 4'h1);
            check($sformatf("lock_pre%0d", i), bus.preempt, 0);
        end
        bus.lock = 1'b0;
        @(negedge clk);
        check("unlock_gnt", bus.gnt, 0);
        check("unlock_pre", bus.preempt, 1);
        @(negedge clk);
        check("unlock_next", bus.gnt, 4'h2);
        check("unlock_id", bus.gnt_id, 1);

        // Sole owner keeps the bus indefinitely, then an asynchronous reset between edges.
        do_reset();
        bus.req = 4'h4;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("sole_gnt%0d", i), bus.gnt, 4'h4);
            check($sformatf("sole_pre%0d", i), bus.preempt, 0);
        end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_gnt", bus.gnt, 0);
        check("async_busy", bus.busy, 0);
        check("async_id", bus.gnt_id, 0);
        @(negedge clk);
        rst = 1'b1;
        bus.req = 4'hf;
        @(negedge clk);
        check("async_regrant", bus.gnt, 4'h1);

        // Owner drops its request on the timeout edge: release, not preempt.
        do_reset();
        bus.req = 4'hf;
        repeat (3) @(negedge clk);
        @(negedge clk);
        check("tmo_owner", bus.gnt, 4'h1);
        bus.req = 4'he;
        @(negedge clk);
        check("tmo_gnt", bus.gnt, 0);
        check("tmo_pre", bus.preempt, 0);
        @(negedge clk);
        check("tmo_next", bus.gnt, 4'h2);

        // Random traffic checked by the scoreboard, including wrap and forgotten requests.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            bus.req  = 4'($urandom_range(0, 15));
            bus.lock = ($urandom_range(0, 3) == 0);
        end
        bus.req  = '0;
        bus.lock = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
